uart_bps_gen: RTL

- Parametrised baud-rate generator for the UART TX and RX paths, replacing the fixed-divisor bit-tick counter.
- Divisor is loadable at run time, and updates are deferred to a frame boundary.
- Emits a mid-bit sample strobe, an end-of-bit strobe, a bit index and a frame-complete strobe, so the TX/RX shift FSMs no longer count bits themselves.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_ovs_cnt.sv | 27 ++
 rtl/uart_bps_gen.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: divisor helper, minimum divisor, FSM states.
package uart_pkg;

  // Smallest legal divisor; keeps the mid-bit and end-of-bit strobes apart.
  localparam int MIN_DIV = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Bit period in clocks minus one for a given clock and baud rate.
  function automatic int default_div(input int clk_hz, input int baud);
    return (clk_hz / baud) - 1;
  endfunction

endpackage

// File: rtl/uart_ovs_cnt.sv
// Oversample counter: free-runs while enabled with period ovs_q_i+1 and is
// re-aligned at every bit boundary so the oversample phase never drifts.
module uart_ovs_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] ovs_q_i,
  output logic             tick_o
);

  logic [CNT_W-1:0] ocnt_q;
  logic             wrap;

  assign wrap   = (ocnt_q == ovs_q_i);
  assign tick_o = en_i && wrap;

  // Count while running; clear when idle, at bit_end and on wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     ocnt_q <= '0;
    else if (!en_i || clr_i || wrap) ocnt_q <= '0;
    else                            ocnt_q <= ocnt_q + 1'b1;
  end

endmodule

// File: rtl/uart_bps_gen.sv
// Baud-rate generator for the UART TX/RX shift paths. Produces mid-bit and
// end-of-bit strobes, the bit index and a frame-complete strobe. Divisor
// changes requested while running are held until the frame boundary.
// Optional oversample tick enabled by defining UART_BPS_OVS_EN.
module uart_bps_gen
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD_DEF   = 9600,
  parameter int CNT_W      = 16,
  parameter int FRAME_BITS = 10,
  parameter int OVS        = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          run,
  input  logic                          div_load,
  input  logic [CNT_W-1:0]              div_val,
  output logic                          bps_sig,
  output logic                          bit_end,
  output logic [$clog2(FRAME_BITS)-1:0] bit_idx,
  output logic                          frame_done,
  output logic                          busy,
  output logic                          ovs_tick
);

  localparam int               IDX_W     = $clog2(FRAME_BITS);
  localparam int               DIV_RST_I = default_div(CLK_HZ, BAUD_DEF);
  localparam logic [CNT_W-1:0] DIV_RST   = CNT_W'(DIV_RST_I);
  localparam logic [CNT_W-1:0] HALF_RST  = CNT_W'((DIV_RST_I + 1) / 2);
  localparam logic [CNT_W-1:0] DIV_MIN   = CNT_W'(MIN_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_BITS - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] bit_idx_q;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] div_clamped;
  logic [CNT_W:0]   div_p1_d;
  logic             wrap;
  logic             boundary;

  // Strobes decode registered state only, so no input reaches an output.
  assign wrap       = (cnt_q == div_q);
  assign busy       = (state_q == RUN);
  assign bps_sig    = busy && (cnt_q == half_q);
  assign bit_end    = busy && wrap;
  assign frame_done = bit_end && (bit_idx_q == LAST_IDX);
  assign bit_idx    = bit_idx_q;

  assign div_clamped = (div_val < DIV_MIN) ? DIV_MIN : div_val;
  // Edges where a new divisor may take effect without disturbing a frame.
  assign boundary    = busy && (frame_done || !run);

  // Divisor bookkeeping: apply directly when idle or at a boundary, else defer.
  always_comb begin
    div_d      = div_q;
    pend_d     = pend_q;
    pend_div_d = pend_div_q;
    if (!busy || boundary) begin
      if (div_load) begin
        div_d  = div_clamped;
        pend_d = 1'b0;
      end else if (pend_q) begin
        div_d  = pend_div_q;
        pend_d = 1'b0;
      end
    end else if (div_load) begin
      pend_div_d = div_clamped;
      pend_d     = 1'b1;
    end
    div_p1_d = {1'b0, div_d} + {{CNT_W{1'b0}}, 1'b1};
    half_d   = div_p1_d[CNT_W:1];
  end

  // Divisor, half-period and pending-request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= DIV_RST;
      half_q     <= HALF_RST;
      pend_div_q <= '0;
      pend_q     <= 1'b0;
    end else begin
      div_q      <= div_d;
      half_q     <= half_d;
      pend_div_q <= pend_div_d;
      pend_q     <= pend_d;
    end
  end

  // Bit-timing FSM: count clocks per bit and bits per frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (run) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            bit_idx_q <= '0;
          end
        end
        RUN: begin
          if (!run) begin
            // Abort or end of the last frame: clear everything.
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
          end else if (wrap) begin
            cnt_q     <= '0;
            bit_idx_q <= (bit_idx_q == LAST_IDX) ? '0 : bit_idx_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef UART_BPS_OVS_EN
  localparam logic [CNT_W:0] OVS_W = (CNT_W + 1)'(OVS);

  logic [CNT_W:0]   div_p1_q;
  logic [CNT_W:0]   ovs_div;
  logic [CNT_W:0]   ovs_m1;
  logic [CNT_W-1:0] ovs_q;

  // Oversample period from the active divisor, floored at one clock.
  assign div_p1_q = {1'b0, div_q} + {{CNT_W{1'b0}}, 1'b1};
  assign ovs_div  = div_p1_q / OVS_W;
  assign ovs_m1   = ovs_div - {{CNT_W{1'b0}}, 1'b1};
  assign ovs_q    = (ovs_div == '0) ? '0 : ovs_m1[CNT_W-1:0];

  uart_ovs_cnt #(.CNT_W(CNT_W)) u_ovs (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (busy),
    .clr_i   (bit_end),
    .ovs_q_i (ovs_q),
    .tick_o  (ovs_tick)
  );
`else
  assign ovs_tick = 1'b0;
`endif

endmodule
